// File: rtl/ysyx_23060124_ifu_fetch_pkg.sv
// Shared core constants for the instruction fetch unit.
package ysyx_23060124_ifu_fetch_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned RESP_W    = 2;
  localparam int unsigned STATE_W   = 2;

  localparam logic [XLEN-1:0]   RESET_PC_DEF = 32'h8000_0000;
  localparam logic [XLEN-1:0]   INS_NOP      = 32'h0000_0013;
  localparam logic [RESP_W-1:0] RESP_OKAY    = 2'b00;

  typedef enum logic [STATE_W-1:0] {
    S_AR   = 2'd0,
    S_R    = 2'd1,
    S_OUT  = 2'd2,
    S_WAIT = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/ysyx_23060124_ifu_fetch.sv
// Instruction fetch unit: issues one read per retired instruction and hands
// the fetched word to decode with a valid/ready handshake.
module ysyx_23060124_ifu_fetch
  import ysyx_23060124_ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pc_update,
  input  logic [31:0] i_npc,
  output logic [31:0] o_araddr,
  output logic        o_arvalid,
  input  logic        i_arready,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rresp,
  input  logic        i_rvalid,
  output logic        o_rready,
  output logic [31:0] o_ins,
  output logic [31:0] o_pc,
  output logic        o_post_valid,
  input  logic        i_post_ready,
  output logic        o_fetch_err
);

  ifu_state_e  state;
  logic [31:0] pc;
  logic [31:0] ins;
  logic        fetch_err;
  logic        arvalid;
  logic        rready;
  logic        post_valid;

  // Fetch FSM; handshake outputs are flops so they stay low while in reset
  // and only rise on the first edge after release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_AR;
      pc         <= RESET_PC;
      ins        <= INS_NOP;
      fetch_err  <= 1'b0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      post_valid <= 1'b0;
    end else begin
      case (state)
        S_AR: begin
          arvalid <= 1'b1;
          if (arvalid && i_arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_R;
          end
        end
        S_R: begin
          if (i_rvalid) begin
            ins        <= i_rdata;
            rready     <= 1'b0;
            post_valid <= 1'b1;
            state      <= S_OUT;
            if (i_rresp != RESP_OKAY) begin
              fetch_err <= 1'b1;
            end
          end
        end
        S_OUT: begin
          if (i_post_ready) begin
            post_valid <= 1'b0;
            // A retire pulse coincident with the hand-off skips S_WAIT.
            if (i_pc_update) begin
              pc      <= i_npc;
              arvalid <= 1'b1;
              state   <= S_AR;
            end else begin
              state   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (i_pc_update) begin
            pc      <= i_npc;
            arvalid <= 1'b1;
            state   <= S_AR;
          end
        end
        default: begin
          state <= S_AR;
        end
      endcase
    end
  end

  assign o_araddr     = pc;
  assign o_arvalid    = arvalid;
  assign o_rready     = rready;
  assign o_ins        = ins;
  assign o_pc         = pc;
  assign o_post_valid = post_valid;
  assign o_fetch_err  = fetch_err;

endmodule

// File: tb/tb_ysyx_23060124_ifu_fetch.sv
// Directed bench for the fetch unit; inputs change and outputs are sampled
// on the falling edge.
module tb_ysyx_23060124_ifu_fetch;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_pc_update;
  logic [31:0] i_npc;
  logic [31:0] o_araddr;
  logic        o_arvalid;
  logic        i_arready;
  logic [31:0] i_rdata;
  logic [1:0]  i_rresp;
  logic        i_rvalid;
  logic        o_rready;
  logic [31:0] o_ins;
  logic [31:0] o_pc;
  logic        o_post_valid;
  logic        i_post_ready;
  logic        o_fetch_err;

  int checks = 0;
  int errors = 0;

  ysyx_23060124_ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_pc_update  (i_pc_update),
    .i_npc        (i_npc),
    .o_araddr     (o_araddr),
    .o_arvalid    (o_arvalid),
    .i_arready    (i_arready),
    .i_rdata      (i_rdata),
    .i_rresp      (i_rresp),
    .i_rvalid     (i_rvalid),
    .o_rready     (o_rready),
    .o_ins        (o_ins),
    .o_pc         (o_pc),
    .o_post_valid (o_post_valid),
    .i_post_ready (i_post_ready),
    .o_fetch_err  (o_fetch_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  initial begin
    i_rst_n      = 1'b0;
    i_pc_update  = 1'b0;
    i_npc        = 32'h0;
    i_arready    = 1'b1;
    i_rdata      = 32'h0010_0093;
    i_rresp      = 2'b00;
    i_rvalid     = 1'b1;
    i_post_ready = 1'b0;

    // reset values
    repeat (2) @(negedge i_clk);
    check_eq("rst_arvalid", 32'(o_arvalid), 32'd0);
    check_eq("rst_rready", 32'(o_rready), 32'd0);
    check_eq("rst_post_valid", 32'(o_post_valid), 32'd0);
    check_eq("rst_ins", o_ins, 32'h0000_0013);
    check_eq("rst_err", 32'(o_fetch_err), 32'd0);
    check_eq("rst_araddr", o_araddr, 32'h8000_0000);

    // zero-wait first fetch
    i_rst_n = 1'b1;
    step();
    check_eq("c1_arvalid", 32'(o_arvalid), 32'd1);
    check_eq("c1_araddr", o_araddr, 32'h8000_0000);
    step();
    check_eq("c2_rready", 32'(o_rready), 32'd1);
    check_eq("c2_arvalid", 32'(o_arvalid), 32'd0);
    step();
    check_eq("c3_post_valid", 32'(o_post_valid), 32'd1);
    check_eq("c3_ins", o_ins, 32'h0010_0093);
    check_eq("c3_pc", o_pc, 32'h8000_0000);
    i_rvalid = 1'b0;
    i_rdata  = 32'hffff_ffff;

    // decode back-pressure
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("bp_post_valid", 32'(o_post_valid), 32'd1);
      check_eq("bp_ins", o_ins, 32'h0010_0093);
      check_eq("bp_pc", o_pc, 32'h8000_0000);
      check_eq("bp_arvalid", 32'(o_arvalid), 32'd0);
    end

    // retire pulse coincident with the hand-off
    i_post_ready = 1'b1;
    i_pc_update  = 1'b1;
    i_npc        = 32'h8000_0100;
    step();
    check_eq("bypass_arvalid", 32'(o_arvalid), 32'd1);
    check_eq("bypass_araddr", o_araddr, 32'h8000_0100);
    check_eq("bypass_post_valid", 32'(o_post_valid), 32'd0);
    i_post_ready = 1'b0;
    i_pc_update  = 1'b0;
    i_arready    = 1'b0;

    // address stall
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("stall_arvalid", 32'(o_arvalid), 32'd1);
      check_eq("stall_araddr", o_araddr, 32'h8000_0100);
      check_eq("stall_rready", 32'(o_rready), 32'd0);
    end
    i_arready = 1'b1;
    step();
    check_eq("ar_done_rready", 32'(o_rready), 32'd1);
    check_eq("ar_done_arvalid", 32'(o_arvalid), 32'd0);
    i_arready = 1'b0;
    step();
    check_eq("r_wait_rready", 32'(o_rready), 32'd1);
    check_eq("r_wait_arvalid", 32'(o_arvalid), 32'd0);

    // error response is forwarded and sticky
    i_rvalid = 1'b1;
    i_rdata  = 32'hdead_beef;
    i_rresp  = 2'b10;
    step();
    check_eq("err_flag", 32'(o_fetch_err), 32'd1);
    check_eq("err_ins", o_ins, 32'hdead_beef);
    check_eq("err_post_valid", 32'(o_post_valid), 32'd1);
    i_rvalid     = 1'b0;
    i_rresp      = 2'b00;
    i_post_ready = 1'b1;
    step();
    check_eq("wait_post_valid", 32'(o_post_valid), 32'd0);
    check_eq("wait_arvalid", 32'(o_arvalid), 32'd0);
    i_post_ready = 1'b0;
    step();
    check_eq("wait_hold_arvalid", 32'(o_arvalid), 32'd0);
    i_pc_update = 1'b1;
    i_npc       = 32'h8000_0104;
    step();
    check_eq("wait_exit_arvalid", 32'(o_arvalid), 32'd1);
    check_eq("wait_exit_araddr", o_araddr, 32'h8000_0104);

    // retire pulses during S_AR/S_R are ignored
    i_npc     = 32'h1234_5678;
    i_arready = 1'b1;
    step();
    check_eq("ign_rready", 32'(o_rready), 32'd1);
    check_eq("ign_araddr", o_araddr, 32'h8000_0104);
    i_arready = 1'b0;
    i_rvalid  = 1'b1;
    i_rdata   = 32'h0000_0013;
    step();
    check_eq("ign_pc", o_pc, 32'h8000_0104);
    check_eq("ign_ins", o_ins, 32'h0000_0013);
    check_eq("sticky_err", 32'(o_fetch_err), 32'd1);
    i_rvalid = 1'b0;

    // reset during the data phase
    i_post_ready = 1'b1;
    i_npc        = 32'h8000_0200;
    step();
    check_eq("pre_rst_araddr", o_araddr, 32'h8000_0200);
    i_pc_update  = 1'b0;
    i_post_ready = 1'b0;
    i_arready    = 1'b1;
    step();
    check_eq("pre_rst_rready", 32'(o_rready), 32'd1);
    i_rst_n = 1'b0;
    #1;
    check_eq("midrst_rready", 32'(o_rready), 32'd0);
    check_eq("midrst_arvalid", 32'(o_arvalid), 32'd0);
    check_eq("midrst_err", 32'(o_fetch_err), 32'd0);
    check_eq("midrst_araddr", o_araddr, 32'h8000_0000);
    @(negedge i_clk);
    i_rst_n  = 1'b1;
    i_rvalid = 1'b1;
    step();
    check_eq("post_rst_arvalid", 32'(o_arvalid), 32'd1);
    check_eq("post_rst_araddr", o_araddr, 32'h8000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
